// File: rtl/eeprom_pkg.sv
// Shared definitions for the calibration EEPROM SPI responder: command encoding,
// frame field positions and the calibration table geometry.
package eeprom_pkg;

    typedef enum logic [1:0] {
        CMD_RD   = 2'b00,
        CMD_WR   = 2'b01,
        CMD_STAT = 2'b10,
        CMD_ILL  = 2'b11
    } eep_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_DECODE = 2'b10
    } eep_state_t;

    localparam int FRAME_BITS = 16;
    localparam int CMD_MSB    = 15;
    localparam int CH_MSB     = 13;
    localparam int GGG_MSB    = 11;
    localparam int SEL_BIT    = 8;
    localparam int DATA_MSB   = 7;
    localparam int TBL_DEPTH  = 32;

    localparam logic [1:0] CH_UNMAPPED = 2'b11;
    localparam logic [4:0] CNT_SAT     = 5'd17;

    function automatic logic [4:0] tbl_idx(input logic [1:0] ch, input logic [2:0] ggg);
        return {ch, ggg};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with rise/fall detection
// taken from the last two synchronized samples.
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/eeprom_spi_resp.sv
// SPI mode-0 slave emulating the calibration EEPROM: 16-bit frames, gain/offset
// table, out-of-frame read responses returned during the following frame.
module eeprom_spi_resp
    import eeprom_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] GAIN_RST    = 8'h80,
    parameter logic [7:0] OFFSET_RST  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        cmd_valid,
    output logic [15:0] cmd_word,
    output logic        wr_strobe,
    output logic        frame_err
);

    logic ss_level, ss_rise, ss_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_s;
    logic [1:0] mosi_edge_unused;

    // SS_n idles high so its synchronizer resets high to avoid a false frame start.
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .din(SS_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(SCLK),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(MOSI),
        .level(mosi_s), .rise(mosi_edge_unused[1]), .fall(mosi_edge_unused[0])
    );

    eep_state_t  state_q, state_d;
    logic [15:0] rx_shft_q, rx_shft_d;
    logic [15:0] tx_shft_q, tx_shft_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  resp_q, resp_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [15:0] cmd_word_q, cmd_word_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  gain_tbl_q   [TBL_DEPTH];
    logic [7:0]  gain_tbl_d   [TBL_DEPTH];
    logic [7:0]  offset_tbl_q [TBL_DEPTH];
    logic [7:0]  offset_tbl_d [TBL_DEPTH];

    logic [15:0] rx_next;
    logic [4:0]  cnt_next;
    eep_cmd_t    cmd;
    logic [1:0]  ch;
    logic [4:0]  idx;
    logic        sel;
    logic [7:0]  data;

    always_comb begin
        state_d      = state_q;
        rx_shft_d    = rx_shft_q;
        tx_shft_d    = tx_shft_q;
        bit_cnt_d    = bit_cnt_q;
        resp_d       = resp_q;
        cmd_valid_d  = 1'b0;
        cmd_word_d   = cmd_word_q;
        wr_strobe_d  = 1'b0;
        frame_err_d  = frame_err_q;
        gain_tbl_d   = gain_tbl_q;
        offset_tbl_d = offset_tbl_q;

        // A shift coinciding with the SS_n rise is applied before the length check.
        rx_next  = rx_shft_q;
        cnt_next = bit_cnt_q;
        if (sclk_rise) begin
            rx_next  = {rx_shft_q[14:0], mosi_s};
            cnt_next = (bit_cnt_q == CNT_SAT) ? CNT_SAT : bit_cnt_q + 5'd1;
        end

        cmd  = eep_cmd_t'(rx_shft_q[CMD_MSB -: 2]);
        ch   = rx_shft_q[CH_MSB -: 2];
        idx  = tbl_idx(ch, rx_shft_q[GGG_MSB -: 3]);
        sel  = rx_shft_q[SEL_BIT];
        data = rx_shft_q[DATA_MSB:0];

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d   = ST_SHIFT;
                    tx_shft_d = {8'h00, resp_q};
                    bit_cnt_d = 5'd0;
                end
            end
            ST_SHIFT: begin
                rx_shft_d = rx_next;
                bit_cnt_d = cnt_next;
                if (sclk_fall) begin
                    tx_shft_d = {tx_shft_q[14:0], 1'b0};
                end
                if (ss_rise) begin
                    if (cnt_next == 5'(FRAME_BITS)) begin
                        state_d = ST_DECODE;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                cmd_valid_d = 1'b1;
                cmd_word_d  = rx_shft_q;
                case (cmd)
                    CMD_RD: begin
                        if (ch == CH_UNMAPPED) begin
                            resp_d = 8'h00;
                        end else begin
                            resp_d      = sel ? gain_tbl_q[idx] : offset_tbl_q[idx];
                            frame_err_d = 1'b0;
                        end
                    end
                    CMD_WR: begin
                        if (ch == CH_UNMAPPED) begin
                            frame_err_d = 1'b1;
                        end else begin
                            if (sel) gain_tbl_d[idx]   = data;
                            else     offset_tbl_d[idx] = data;
                            wr_strobe_d = 1'b1;
                            resp_d      = data;
                            frame_err_d = 1'b0;
                        end
                    end
                    CMD_STAT: begin
                        resp_d = {5'b0, frame_err_q, 2'b01};
                        if (ch != CH_UNMAPPED) frame_err_d = 1'b0;
                    end
                    CMD_ILL: begin
                        frame_err_d = 1'b1;
                    end
                endcase
                // A new frame may already have started; it must see this frame's response.
                state_d = ST_IDLE;
                if (ss_fall) begin
                    state_d   = ST_SHIFT;
                    tx_shft_d = {8'h00, resp_d};
                    bit_cnt_d = 5'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rx_shft_q   <= 16'h0000;
            tx_shft_q   <= 16'h0000;
            bit_cnt_q   <= 5'd0;
            resp_q      <= 8'h00;
            cmd_valid_q <= 1'b0;
            cmd_word_q  <= 16'h0000;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < TBL_DEPTH; i++) begin
                gain_tbl_q[i]   <= GAIN_RST;
                offset_tbl_q[i] <= OFFSET_RST;
            end
        end else begin
            state_q      <= state_d;
            rx_shft_q    <= rx_shft_d;
            tx_shft_q    <= tx_shft_d;
            bit_cnt_q    <= bit_cnt_d;
            resp_q       <= resp_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_word_q   <= cmd_word_d;
            wr_strobe_q  <= wr_strobe_d;
            frame_err_q  <= frame_err_d;
            gain_tbl_q   <= gain_tbl_d;
            offset_tbl_q <= offset_tbl_d;
        end
    end

    assign MISO      = ss_level ? 1'bz : tx_shft_q[15];
    assign cmd_valid = cmd_valid_q;
    assign cmd_word  = cmd_word_q;
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;

endmodule
